layer01_load: RTL and testbench

Reads 128-bit words back out of the 16-bank on-chip feature buffer and streams them as 32-bit beats to the next layer's compute input. It is the read-side counterpart of the layer-00 writer, which packs four 32-bit outputs into one 128-bit word (beat 0 in bits [31:0]) across 16 byte-lane banks. This block issues shared-address reads, waits out the SRAM latency, and unpacks each word back into the original beat order under valid/ready flow control.

---
 rtl/layer_buf_pkg.sv | 9 +
 rtl/layer01_load_if.sv | 18 +
 rtl/layer_word_ser.sv | 29 ++
 rtl/layer01_load.sv | 59 +++++
 tb/tb_layer01_load.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/layer_buf_pkg.sv
// layer_buf_pkg: shared feature-buffer geometry and the load-side FSM state type
package layer_buf_pkg;
  localparam int NUM_BANKS      = 16;
  localparam int BANK_W         = 8;
  localparam int WORD_W         = 128;
  localparam int BEAT_W         = 32;
  localparam int BEATS_PER_WORD = 4;
  typedef enum logic [2:0] {IDLE, RD, WAIT, SER, DONE} load_state_t;
endpackage

// File: rtl/layer01_load_if.sv
// layer01_load_if: control, SRAM read port and beat stream of the layer-01 loader
interface layer01_load_if import layer_buf_pkg::*; #(parameter int ADDR_W = 10, parameter int CNT_W = 10) ();
  logic                 i_start;
  logic [ADDR_W-1:0]    i_base_addr;
  logic [CNT_W-1:0]     i_num_words;
  logic [ADDR_W-1:0]    o_addr;
  logic [NUM_BANKS-1:0] o_cs;
  logic [WORD_W-1:0]    i_rdata;
  logic [BEAT_W-1:0]    o_data;
  logic                 o_vld;
  logic                 i_rdy;
  logic                 o_busy;
  logic                 o_done;
  modport master (input i_start, i_base_addr, i_num_words, i_rdata, i_rdy,
                  output o_addr, o_cs, o_data, o_vld, o_busy, o_done);
  modport slave  (output i_start, i_base_addr, i_num_words, i_rdata, i_rdy,
                  input o_addr, o_cs, o_data, o_vld, o_busy, o_done);
endinterface

// File: rtl/layer_word_ser.sv
// layer_word_ser: holds one 128-bit word and unpacks it into four 32-bit beats, beat 0 first
module layer_word_ser import layer_buf_pkg::*; (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [WORD_W-1:0] rdata,
  input  logic              en,
  input  logic              rdy,
  output logic [BEAT_W-1:0] data,
  output logic              vld,
  output logic              last
);
  logic [WORD_W-1:0] word;
  logic [1:0]        b;
  assign vld  = en;
  assign data = word[BEAT_W*int'(b) +: BEAT_W];
  assign last = en & rdy & (b == 2'(BEATS_PER_WORD-1));
  // beat index only moves on acceptance, so data/vld hold under backpressure
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      word <= '0;
      b    <= '0;
    end else if (load) begin
      word <= rdata;
      b    <= '0;
    end else if (en && rdy) begin
      b    <= b + 2'd1;
    end
endmodule

// File: rtl/layer01_load.sv
// layer01_load: reads 128-bit words from the banked feature buffer and streams them as 32-bit beats
module layer01_load import layer_buf_pkg::*; #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 10,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rstn,
  layer01_load_if.master bus
);
  load_state_t       state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        lat;
  logic              lat_end, last;
  assign lat_end     = lat == 2'(RD_LAT-1);
  assign bus.o_addr  = addr;
  assign bus.o_cs    = state == RD ? '1 : '0;
  assign bus.o_busy  = state != IDLE;
  assign bus.o_done  = state == DONE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.i_start) state_n = bus.i_num_words != '0 ? RD : DONE;
      RD:      state_n = WAIT;
      WAIT:    if (lat_end) state_n = SER;
      SER:     if (last) state_n = cnt == CNT_W'(1) ? DONE : RD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      addr  <= '0;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_n;
      lat   <= state == WAIT ? lat + 2'd1 : '0;
      if (state == IDLE && bus.i_start) begin
        addr <= bus.i_base_addr;
        cnt  <= bus.i_num_words;
      end else if (last) begin
        addr <= addr + ADDR_W'(1);
        cnt  <= cnt - CNT_W'(1);
      end
    end
  layer_word_ser u_ser (
    .clk   (clk),
    .rstn  (rstn),
    .load  (state == WAIT && lat_end),
    .rdata (bus.i_rdata),
    .en    (state == SER),
    .rdy   (bus.i_rdy),
    .data  (bus.o_data),
    .vld   (bus.o_vld),
    .last  (last)
  );
endmodule

// File: tb/tb_layer01_load.sv
// tb_layer01_load: directed scoreboard bench for the layer-01 word loader
module tb_layer01_load;
  logic clk = 0;
  logic rstn = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int exp_done = 0;
  logic [127:0] mem [1024];
  logic [31:0]  exp_beats [$];
  logic [9:0]   exp_addr [$];

  always #5 clk = ~clk;

  layer01_load_if #(.ADDR_W(10), .CNT_W(10)) bus ();
  layer01_load #(.ADDR_W(10), .CNT_W(10), .RD_LAT(1)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  // one-cycle synchronous SRAM; garbage outside the valid cycle exposes mistimed captures
  always @(posedge clk)
    bus.i_rdata <= bus.o_cs == 16'hFFFF ? mem[bus.o_addr] : 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.o_done) done_cnt++;
    if (bus.o_cs != '0) begin
      chk("cs_val", 128'(bus.o_cs), 128'hFFFF);
      if (exp_addr.size() == 0) chk("rd_addr_extra", 128'(bus.o_addr), 128'hFFFF_FFFF);
      else chk("rd_addr", 128'(bus.o_addr), 128'(exp_addr.pop_front()));
    end
    if (bus.o_vld && bus.i_rdy) begin
      if (exp_beats.size() == 0) chk("beat_extra", 128'(bus.o_data), 128'hFFFF_FFFF_FFFF);
      else chk("beat", 128'(bus.o_data), 128'(exp_beats.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [9:0] base, input logic [9:0] num);
    logic [9:0] a;
    bus.i_start     = 1;
    bus.i_base_addr = base;
    bus.i_num_words = num;
    for (int w = 0; w < int'(num); w++) begin
      a = base + 10'(w);
      exp_addr.push_back(a);
      for (int j = 0; j < 4; j++) exp_beats.push_back(mem[a][32*j +: 32]);
    end
    exp_done++;
    tick();
    bus.i_start = 0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.o_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 128'(n < 200), 128'(1));
    tick();
  endtask

  task automatic drained(input string tag);
    chk({tag, "_beats_left"}, 128'(exp_beats.size()), 128'(0));
    chk({tag, "_addr_left"}, 128'(exp_addr.size()), 128'(0));
    chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(exp_done));
  endtask

  initial begin
    for (int a = 0; a < 1024; a++)
      for (int j = 0; j < 4; j++) mem[a][32*j +: 32] = 32'hA000_0000 | (a << 4) | j;
    mem[5] = 128'h00000004_00000003_00000002_00000001;
    bus.i_start = 0;
    bus.i_base_addr = '0;
    bus.i_num_words = '0;
    bus.i_rdy = 1;
    tick();
    @(negedge clk);
    chk("reset_outs", 128'({bus.o_addr, bus.o_cs, bus.o_data, bus.o_vld, bus.o_busy, bus.o_done}), 128'(0));
    tick();
    rstn = 1;
    tick();

    // single word with cycle-exact timing
    start(10'd5, 10'd1);
    @(negedge clk);
    chk("t1_cs", 128'(bus.o_cs), 128'hFFFF);
    chk("t1_addr", 128'(bus.o_addr), 128'd5);
    tick();
    @(negedge clk);
    chk("t1_wait_vld", 128'(bus.o_vld), 128'(0));
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("t1_vld", 128'(bus.o_vld), 128'(1));
      chk("t1_data", 128'(bus.o_data), 128'(i + 1));
    end
    tick();
    @(negedge clk);
    chk("t1_done", 128'(bus.o_done), 128'(1));
    tick();
    @(negedge clk);
    chk("t1_idle", 128'({bus.o_busy, bus.o_done}), 128'(0));
    drained("t1");
    tick();

    // multi-word with address wrap
    start(10'h3FE, 10'd3);
    wait_done("t2_timeout");
    drained("t2");

    // backpressure on beat 2
    start(10'd20, 10'd2);
    repeat (4) tick();
    bus.i_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_vld", 128'(bus.o_vld), 128'(1));
      chk("bp_data", 128'(bus.o_data), 128'(mem[20][95:64]));
      tick();
    end
    bus.i_rdy = 1;
    wait_done("t3_timeout");
    drained("t3");

    // zero count
    start(10'd9, 10'd0);
    @(negedge clk);
    chk("z_done", 128'(bus.o_done), 128'(1));
    chk("z_cs", 128'(bus.o_cs), 128'(0));
    tick();
    @(negedge clk);
    chk("z_idle", 128'({bus.o_busy, bus.o_done, bus.o_cs}), 128'(0));
    drained("t4");
    tick();

    // start pulse while busy is dropped
    start(10'd40, 10'd2);
    repeat (3) tick();
    bus.i_start = 1;
    bus.i_base_addr = 10'd100;
    bus.i_num_words = 10'd5;
    tick();
    bus.i_start = 0;
    wait_done("t5_timeout");
    repeat (3) tick();
    @(negedge clk);
    chk("t5_no_requeue", 128'(bus.o_busy), 128'(0));
    drained("t5");
    tick();

    // reset in the middle of SER
    start(10'd60, 10'd2);
    repeat (3) tick();
    #2;
    rstn = 0;
    #1;
    chk("rst_outs", 128'({bus.o_addr, bus.o_cs, bus.o_data, bus.o_vld, bus.o_busy, bus.o_done}), 128'(0));
    exp_beats.delete();
    exp_addr.delete();
    exp_done--;
    tick();
    tick();
    chk("rst_idle", 128'(bus.o_busy), 128'(0));
    rstn = 1;
    tick();
    start(10'd70, 10'd1);
    @(negedge clk);
    chk("post_rst_addr", 128'(bus.o_addr), 128'd70);
    wait_done("t6_timeout");
    drained("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
